// File: rtl/qs_fifo.sv
`default_nettype none
// ============================================================================
// Module   : qs_fifo
// Purpose  : Single-clock synchronous FIFO, first-word fall-through. The head
//            entry is always presented on pop_data_o (zero while empty).
//            Depth need not be a power of two; pointers wrap explicitly.
// Ports    : clk          - clock, all state updates on the rising edge
//            reset        - synchronous reset, active-low
//            push_i       - push request (accepted when not full, or when a
//                           pop happens in the same cycle)
//            push_data_i  - data to enqueue
//            pop_i        - pop request (accepted when not empty)
//            pop_data_o   - head entry, combinational
//            full_o       - FIFO holds DEPTH entries
//            empty_o      - FIFO holds no entries
// Revision : 1.0 - initial release
// ============================================================================
module qs_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push_acc;
    logic w_pop_acc;

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == c_CNT_W'(DEPTH));

    // A push into a full FIFO is still accepted when a pop frees the head slot
    // in the same cycle.
    assign w_push_acc = push_i & (~full_o | pop_i);
    assign w_pop_acc  = pop_i & ~empty_o;

    // Storage is deliberately not reset; the empty gating below keeps stale
    // contents from ever reaching the output.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data_o = empty_o ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_qs_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_qs_fifo
// Purpose  : Directed testbench for qs_fifo. Two instances: DEPTH=2 for the
//            flag/boundary cases and DEPTH=3 for pointer wrap and ordering.
//            Accepted pushes enqueue their data into a per-instance scoreboard;
//            a monitor per instance pops and compares on every accepted pop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qs_fifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic       reset_a = 1'b0;
    logic       push_a  = 1'b0;
    logic [7:0] pdata_a = 8'h00;
    logic       pop_a   = 1'b0;
    logic [7:0] dout_a;
    logic       full_a, empty_a;

    // DEPTH=3 instance
    logic       reset_b = 1'b0;
    logic       push_b  = 1'b0;
    logic [7:0] pdata_b = 8'h00;
    logic       pop_b   = 1'b0;
    logic [7:0] dout_b;
    logic       full_b, empty_b;

    qs_fifo #(.DATA_W(8), .DEPTH(2)) u_dut_a (
        .clk         (clk),
        .reset       (reset_a),
        .push_i      (push_a),
        .push_data_i (pdata_a),
        .pop_i       (pop_a),
        .pop_data_o  (dout_a),
        .full_o      (full_a),
        .empty_o     (empty_a)
    );

    qs_fifo #(.DATA_W(8), .DEPTH(3)) u_dut_b (
        .clk         (clk),
        .reset       (reset_b),
        .push_i      (push_b),
        .push_data_i (pdata_b),
        .pop_i       (pop_b),
        .pop_data_o  (dout_b),
        .full_o      (full_b),
        .empty_o     (empty_b)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: on the falling edge, inputs are stable and the head is what
    // the coming rising edge will remove.
    always @(negedge clk) begin
        if (reset_a && pop_a && !empty_a) begin
            if (q_a.size() == 0) begin
                chk("pop_a_unexpected", 32'(dout_a), 32'hFFFF_FFFF);
            end else begin
                chk("pop_a_data", 32'(dout_a), 32'(q_a.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_b && pop_b && !empty_b) begin
            if (q_b.size() == 0) begin
                chk("pop_b_unexpected", 32'(dout_b), 32'hFFFF_FFFF);
            end else begin
                chk("pop_b_data", 32'(dout_b), 32'(q_b.pop_front()));
            end
        end
    end

    // One cycle on instance A. exp_acc says whether the push is expected to be
    // accepted (hand-derived per vector); flags are checked just after the edge.
    task automatic step_a(input logic p, input logic [7:0] d, input logic o,
                          input logic exp_acc, input logic exp_empty,
                          input logic exp_full, input logic [7:0] exp_head);
        push_a  = p;
        pdata_a = d;
        pop_a   = o;
        if (exp_acc) q_a.push_back(d);
        @(posedge clk);
        #1;
        push_a = 1'b0;
        pop_a  = 1'b0;
        chk("a_empty", 32'(empty_a), 32'(exp_empty));
        chk("a_full",  32'(full_a),  32'(exp_full));
        chk("a_head",  32'(dout_a),  32'(exp_head));
    endtask

    task automatic step_b(input logic p, input logic [7:0] d, input logic o,
                          input logic exp_acc, input logic exp_empty,
                          input logic exp_full, input logic [7:0] exp_head);
        push_b  = p;
        pdata_b = d;
        pop_b   = o;
        if (exp_acc) q_b.push_back(d);
        @(posedge clk);
        #1;
        push_b = 1'b0;
        pop_b  = 1'b0;
        chk("b_empty", 32'(empty_b), 32'(exp_empty));
        chk("b_full",  32'(full_b),  32'(exp_full));
        chk("b_head",  32'(dout_b),  32'(exp_head));
    endtask

    initial begin
        // Reset both instances, then idle.
        repeat (2) @(posedge clk);
        #1;
        reset_a = 1'b1;
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_a_empty", 32'(empty_a), 32'd1);
        chk("rst_a_full",  32'(full_a),  32'd0);
        chk("rst_a_head",  32'(dout_a),  32'h00);
        chk("rst_b_empty", 32'(empty_b), 32'd1);

        // ---------------- DEPTH=2 ----------------
        //     push  data   pop  acc  empty full head
        step_a(1'b1, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAB);
        step_a(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAB);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCC);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Push while full, no pop: ignored.
        step_a(1'b1, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAB);
        step_a(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAB);
        step_a(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAB);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCC);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Push and pop together while full: stays full, contents {CC,33}.
        step_a(1'b1, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAB);
        step_a(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAB);
        step_a(1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 8'hCC);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Empty: pop alone ignored; push+pop accepts only the push.
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step_a(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        step_a(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55);

        // Reset with two entries, a push pending in the same cycle.
        reset_a = 1'b0;
        push_a  = 1'b1;
        pdata_a = 8'h99;
        @(posedge clk);
        #1;
        reset_a = 1'b1;
        push_a  = 1'b0;
        q_a.delete();
        chk("mid_rst_empty", 32'(empty_a), 32'd1);
        chk("mid_rst_full",  32'(full_a),  32'd0);
        chk("mid_rst_head",  32'(dout_a),  32'h00);

        // ---------------- DEPTH=3 wrap / ordering ----------------
        step_b(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
        step_b(1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
        step_b(1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
        step_b(1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02);
        step_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
        step_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04);
        step_b(1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
        step_b(1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04);
        step_b(1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 8'h05);
        step_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h06);
        step_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
        step_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step_b(1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 8'h08);
        step_b(1'b1, 8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 8'h09);
        step_b(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h09);
        step_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0A);
        step_b(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Every accepted entry must have been popped and compared.
        chk("a_scoreboard_drained", 32'(q_a.size()), 32'd0);
        chk("b_scoreboard_drained", 32'(q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
